// File: rtl/synth_voice_alloc.sv
// Polyphonic voice allocator: scans the units one per cycle, then assigns the
// note to the matching, free or oldest unit and drives the oscillator buses.
module synth_voice_alloc #(
  parameter int NUM_UNITS  = 4,
  parameter int FREQ_WIDTH = 16,
  parameter int NOTE_WIDTH = 7,
  parameter int AGE_WIDTH  = 8
) (
  input  logic                            ctl_clk,
  input  logic                            ctl_rst,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [NOTE_WIDTH-1:0]           ev_note,
  input  logic [FREQ_WIDTH-1:0]           ev_freq,
  input  logic [1:0]                      ev_wave,
  input  logic                            all_off,
  output logic [FREQ_WIDTH*NUM_UNITS-1:0] freq_out,
  output logic [2*NUM_UNITS-1:0]          wave_type,
  output logic [NUM_UNITS-1:0]            voice_active,
  output logic                            steal_pulse,
  output logic                            drop_pulse
);

  localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_UNITS - 1);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX  = {AGE_WIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   ev_is_on_q, ev_is_on_d;
  logic [NOTE_WIDTH-1:0]  ev_note_q, ev_note_d;
  logic [FREQ_WIDTH-1:0]  ev_freq_q, ev_freq_d;
  logic [1:0]             ev_wave_q, ev_wave_d;
  logic                   match_hit_q, match_hit_d, free_hit_q, free_hit_d, old_hit_q, old_hit_d;
  logic [IDX_W-1:0]       match_idx_q, match_idx_d, free_idx_q, free_idx_d, old_idx_q, old_idx_d;
  logic [AGE_WIDTH-1:0]   old_age_q, old_age_d;
  logic [FREQ_WIDTH-1:0]  freq_q [NUM_UNITS];
  logic [FREQ_WIDTH-1:0]  freq_d [NUM_UNITS];
  logic [1:0]             wave_q [NUM_UNITS];
  logic [1:0]             wave_d [NUM_UNITS];
  logic [NOTE_WIDTH-1:0]  note_q [NUM_UNITS];
  logic [NOTE_WIDTH-1:0]  note_d [NUM_UNITS];
  logic [AGE_WIDTH-1:0]   age_q  [NUM_UNITS];
  logic [AGE_WIDTH-1:0]   age_d  [NUM_UNITS];
  logic [NUM_UNITS-1:0]   active_q, active_d;
  logic                   ev_ready_q, ev_ready_d, steal_q, steal_d, drop_q, drop_d;
  logic [IDX_W-1:0]       tgt_s;

  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (all_off) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ev_valid && ev_ready_q) state_d = SCAN; else state_d = IDLE;
        SCAN:    if (idx_q == LAST_IDX) state_d = COMMIT; else state_d = SCAN;
        COMMIT:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Note-on target priority: retrigger a matching voice, else a free one, else steal the oldest.
  always_comb begin
    if (match_hit_q)     tgt_s = match_idx_q;
    else if (free_hit_q) tgt_s = free_idx_q;
    else                 tgt_s = old_idx_q;
  end

  always_comb begin
    idx_d       = idx_q;
    ev_is_on_d  = ev_is_on_q;
    ev_note_d   = ev_note_q;
    ev_freq_d   = ev_freq_q;
    ev_wave_d   = ev_wave_q;
    match_hit_d = match_hit_q;
    match_idx_d = match_idx_q;
    free_hit_d  = free_hit_q;
    free_idx_d  = free_idx_q;
    old_hit_d   = old_hit_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    freq_d      = freq_q;
    wave_d      = wave_q;
    note_d      = note_q;
    age_d       = age_q;
    active_d    = active_q;
    ev_ready_d  = ev_ready_q;
    steal_d     = 1'b0;
    drop_d      = 1'b0;
    if (all_off) begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        freq_d[i] = '0;
        age_d[i]  = '0;
      end
      active_d   = '0;
      ev_ready_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          ev_ready_d = 1'b1;
          if (ev_valid && ev_ready_q) begin
            // A zero-frequency note-on is handled as a release of that note.
            ev_is_on_d  = ev_on && (ev_freq != '0);
            ev_note_d   = ev_note;
            ev_freq_d   = ev_freq;
            ev_wave_d   = ev_wave;
            ev_ready_d  = 1'b0;
            idx_d       = '0;
            match_hit_d = 1'b0;
            free_hit_d  = 1'b0;
            old_hit_d   = 1'b0;
            old_age_d   = '0;
          end else begin
            idx_d = idx_q;
          end
        end
        SCAN: begin
          if (active_q[idx_q] && !match_hit_q && (note_q[idx_q] == ev_note_q)) begin
            match_hit_d = 1'b1;
            match_idx_d = idx_q;
          end else begin
            match_hit_d = match_hit_q;
          end
          if (!active_q[idx_q] && !free_hit_q) begin
            free_hit_d = 1'b1;
            free_idx_d = idx_q;
          end else begin
            free_hit_d = free_hit_q;
          end
          if (active_q[idx_q] && (!old_hit_q || (age_q[idx_q] > old_age_q))) begin
            old_hit_d = 1'b1;
            old_idx_d = idx_q;
            old_age_d = age_q[idx_q];
          end else begin
            old_hit_d = old_hit_q;
          end
          idx_d = idx_q + IDX_W'(1);
        end
        COMMIT: begin
          ev_ready_d = 1'b1;
          if (ev_is_on_q) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
              if (IDX_W'(i) == tgt_s) begin
                freq_d[i]   = ev_freq_q;
                wave_d[i]   = ev_wave_q;
                note_d[i]   = ev_note_q;
                age_d[i]    = '0;
                active_d[i] = 1'b1;
              end else if (active_q[i] && (age_q[i] != AGE_MAX)) begin
                age_d[i] = age_q[i] + AGE_WIDTH'(1);
              end else begin
                age_d[i] = age_q[i];
              end
            end
            steal_d = !match_hit_q && !free_hit_q;
          end else if (match_hit_q) begin
            freq_d[match_idx_q]   = '0;
            age_d[match_idx_q]    = '0;
            active_d[match_idx_q] = 1'b0;
          end else begin
            drop_d = 1'b1;
          end
        end
        default: ev_ready_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge ctl_clk or negedge ctl_rst) begin
    if (!ctl_rst) begin
      idx_q       <= '0;
      ev_is_on_q  <= 1'b0;
      ev_note_q   <= '0;
      ev_freq_q   <= '0;
      ev_wave_q   <= '0;
      match_hit_q <= 1'b0;
      match_idx_q <= '0;
      free_hit_q  <= 1'b0;
      free_idx_q  <= '0;
      old_hit_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
      for (int i = 0; i < NUM_UNITS; i++) begin
        freq_q[i] <= '0;
        wave_q[i] <= '0;
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
      active_q    <= '0;
      ev_ready_q  <= 1'b0;
      steal_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      ev_is_on_q  <= ev_is_on_d;
      ev_note_q   <= ev_note_d;
      ev_freq_q   <= ev_freq_d;
      ev_wave_q   <= ev_wave_d;
      match_hit_q <= match_hit_d;
      match_idx_q <= match_idx_d;
      free_hit_q  <= free_hit_d;
      free_idx_q  <= free_idx_d;
      old_hit_q   <= old_hit_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
      freq_q      <= freq_d;
      wave_q      <= wave_d;
      note_q      <= note_d;
      age_q       <= age_d;
      active_q    <= active_d;
      ev_ready_q  <= ev_ready_d;
      steal_q     <= steal_d;
      drop_q      <= drop_d;
    end
  end

  always_comb begin
    freq_out  = '0;
    wave_type = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      freq_out[FREQ_WIDTH*i +: FREQ_WIDTH] = freq_q[i];
      wave_type[2*i +: 2]                  = wave_q[i];
    end
  end

  assign ev_ready     = ev_ready_q;
  assign voice_active = active_q;
  assign steal_pulse  = steal_q;
  assign drop_pulse   = drop_q;

endmodule

// File: tb/tb_synth_voice_alloc.sv
// Self-checking bench for synth_voice_alloc: directed scenarios plus random
// note traffic compared against a voice-table reference model.
module tb_synth_voice_alloc;

  localparam int N = 4;

  logic        ctl_clk = 1'b0;
  logic        ctl_rst = 1'b0;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic        ev_on = 1'b0;
  logic [6:0]  ev_note = '0;
  logic [15:0] ev_freq = '0;
  logic [1:0]  ev_wave = '0;
  logic        all_off = 1'b0;
  logic [63:0] freq_out;
  logic [7:0]  wave_type;
  logic [3:0]  voice_active;
  logic        steal_pulse;
  logic        drop_pulse;

  int checks = 0;
  int errors = 0;

  // Reference voice table
  bit       m_act  [N];
  int       m_note [N];
  int       m_freq [N];
  int       m_wave [N];
  int       m_age  [N];

  synth_voice_alloc dut (
    .ctl_clk(ctl_clk), .ctl_rst(ctl_rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_freq(ev_freq), .ev_wave(ev_wave),
    .all_off(all_off), .freq_out(freq_out), .wave_type(wave_type),
    .voice_active(voice_active), .steal_pulse(steal_pulse), .drop_pulse(drop_pulse)
  );

  always #5 ctl_clk = ~ctl_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_freq();
    logic [63:0] v = '0;
    for (int i = 0; i < N; i++) v[16*i +: 16] = 16'(m_freq[i]);
    return v;
  endfunction

  function automatic logic [7:0] exp_wave();
    logic [7:0] v = '0;
    for (int i = 0; i < N; i++) v[2*i +: 2] = 2'(m_wave[i]);
    return v;
  endfunction

  function automatic logic [3:0] exp_act();
    logic [3:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_act[i];
    return v;
  endfunction

  task automatic model_clear(input bit clear_wave);
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_freq[i] = 0; m_age[i] = 0;
      if (clear_wave) begin m_wave[i] = 0; m_note[i] = 0; end
    end
  endtask

  task automatic model_apply(input bit on, input int note, input int freq, input int wave,
                             output bit steal, output bit drop);
    int tgt = -1;
    steal = 0; drop = 0;
    for (int i = 0; i < N; i++) if (tgt < 0 && m_act[i] && m_note[i] == note) tgt = i;
    if (on && freq != 0) begin
      if (tgt < 0) for (int i = 0; i < N; i++) if (tgt < 0 && !m_act[i]) tgt = i;
      if (tgt < 0) begin
        int best = -1;
        steal = 1;
        for (int i = 0; i < N; i++) if (m_age[i] > best) begin best = m_age[i]; tgt = i; end
      end
      for (int i = 0; i < N; i++) if (i != tgt && m_act[i] && m_age[i] < 255) m_age[i]++;
      m_act[tgt] = 1; m_note[tgt] = note; m_freq[tgt] = freq; m_wave[tgt] = wave; m_age[tgt] = 0;
    end else if (tgt >= 0) begin
      m_act[tgt] = 0; m_freq[tgt] = 0; m_age[tgt] = 0;
    end else begin
      drop = 1;
    end
  endtask

  task automatic check_buses(input string tag);
    check({tag, "_freq"}, freq_out, exp_freq());
    check({tag, "_wave"}, 64'(wave_type), 64'(exp_wave()));
    check({tag, "_active"}, 64'(voice_active), 64'(exp_act()));
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ev_ready !== 1'b1 && n < 20) begin @(posedge ctl_clk); #1; n++; end
    check("ready_wait", 64'(ev_ready), 64'd1);
  endtask

  // Accept an event on edge T; outputs must hold until T+N+1 and pulses last one cycle.
  task automatic do_event(input bit on, input int note, input int freq, input int wave);
    bit es, ed;
    logic [3:0] prev_act;
    wait_ready();
    @(negedge ctl_clk);
    ev_valid = 1'b1; ev_on = on; ev_note = 7'(note); ev_freq = 16'(freq); ev_wave = 2'(wave);
    @(posedge ctl_clk); #1;
    ev_valid = 1'b0; ev_on = 1'($urandom); ev_note = 7'($urandom);
    ev_freq = 16'($urandom); ev_wave = 2'($urandom);
    prev_act = exp_act();
    model_apply(on, note, freq, wave, es, ed);
    for (int k = 0; k < N; k++) begin
      check("busy_ready", 64'(ev_ready), 64'd0);
      @(posedge ctl_clk); #1;
    end
    check("pre_commit_active", 64'(voice_active), 64'(prev_act));
    @(posedge ctl_clk); #1;
    check_buses("commit");
    check("commit_ready", 64'(ev_ready), 64'd1);
    check("steal", 64'(steal_pulse), 64'(es));
    check("drop", 64'(drop_pulse), 64'(ed));
    @(posedge ctl_clk); #1;
    check("steal_end", 64'(steal_pulse), 64'd0);
    check("drop_end", 64'(drop_pulse), 64'd0);
  endtask

  task automatic start_and_scan(input int note, input int freq);
    wait_ready();
    @(negedge ctl_clk);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'(note); ev_freq = 16'(freq); ev_wave = 2'd2;
    @(posedge ctl_clk); #1;
    ev_valid = 1'b0;
    @(posedge ctl_clk); #1;
    @(posedge ctl_clk); #1;
  endtask

  initial begin
    model_clear(1);
    #12;
    check_buses("reset");
    check("reset_ready", 64'(ev_ready), 64'd0);
    @(negedge ctl_clk); ctl_rst = 1'b1;
    @(posedge ctl_clk); #1;
    check("ready_after_release", 64'(ev_ready), 64'd1);

    // Scenario 1-5
    do_event(1, 60, 440, 1);
    check("s1_unit0", freq_out[63:0], 64'd440);
    do_event(0, 60, 0, 0);
    do_event(1, 60, 440, 1);
    do_event(1, 61, 880, 1);
    do_event(1, 62, 1760, 1);
    do_event(1, 63, 4000, 1);
    check("s2_active", 64'(voice_active), 64'hf);
    do_event(1, 64, 300, 3);
    check("s3_unit0_stolen", 64'(freq_out[15:0]), 64'd300);
    do_event(0, 62, 0, 0);
    check("s4_active", 64'(voice_active), 64'hb);
    do_event(0, 99, 0, 0);
    do_event(1, 61, 900, 0);
    check("s5_unit1", 64'(freq_out[31:16]), 64'd900);
    do_event(1, 63, 0, 0);

    // all_off mid-scan discards the event
    start_and_scan(70, 1234);
    @(negedge ctl_clk); all_off = 1'b1;
    @(posedge ctl_clk); #1;
    all_off = 1'b0;
    model_clear(0);
    check_buses("alloff");
    check("alloff_ready", 64'(ev_ready), 64'd1);
    for (int k = 0; k < N + 2; k++) begin
      @(posedge ctl_clk); #1;
      check("alloff_no_pulse", 64'({steal_pulse, drop_pulse}), 64'd0);
    end
    check_buses("alloff_hold");

    // all_off with ev_valid in IDLE: event must not be taken
    do_event(1, 40, 500, 1);
    @(negedge ctl_clk); all_off = 1'b1; ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd41; ev_freq = 16'd77;
    @(posedge ctl_clk); #1;
    all_off = 1'b0; ev_valid = 1'b0;
    model_clear(0);
    check("idle_alloff_ready", 64'(ev_ready), 64'd1);
    repeat (N + 2) @(posedge ctl_clk);
    #1;
    check_buses("idle_alloff");

    // Random traffic
    for (int r = 0; r < 150; r++) begin
      int f;
      f = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 65535));
      do_event($urandom_range(0, 9) < 6, int'($urandom_range(60, 66)), f, int'($urandom_range(0, 3)));
    end

    // Asynchronous reset mid-scan
    start_and_scan(50, 999);
    #1 ctl_rst = 1'b0;
    #1;
    model_clear(1);
    check_buses("midscan_reset");
    check("midscan_reset_ready", 64'(ev_ready), 64'd0);
    @(negedge ctl_clk); ctl_rst = 1'b1;
    @(posedge ctl_clk); #1;
    check("post_reset_ready", 64'(ev_ready), 64'd1);
    do_event(1, 10, 123, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
